// File: rtl/frac_clk_div_if.sv
// rtl/frac_clk_div_if.sv - configuration offer/response bundle for frac_clk_div
interface frac_clk_div_if #(
    parameter int CNT_W = 8,
    parameter int ACC_W = 8
) ();
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_int;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_int, cfg_num, cfg_den,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_num, cfg_den,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/frac_clk_div.sv
// rtl/frac_clk_div.sv - fractional clock divider, periods of D or D+1 cycles averaging D + num/den
module frac_clk_div #(
    parameter int CNT_W   = 8,
    parameter int ACC_W   = 8,
    parameter int DEF_INT = 8,
    parameter int DEF_NUM = 7,
    parameter int DEF_DEN = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    frac_clk_div_if.slave    cfg,
    output logic             period_tick,
    output logic             clk_out
);
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W:0]   pcnt_q, pcnt_d;
    logic [CNT_W:0]   plen_q, plen_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] act_int_q, act_int_d, sh_int_q, sh_int_d;
    logic [ACC_W-1:0] act_num_q, act_num_d, sh_num_q, sh_num_d;
    logic [ACC_W-1:0] act_den_q, act_den_d, sh_den_q, sh_den_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;

    logic             offer, legal, accept, boundary;
    logic [CNT_W-1:0] sel_int;
    logic [ACC_W-1:0] sel_num, sel_den, sel_acc;
    logic [ACC_W:0]   sum, diff;
    logic [CNT_W:0]   new_plen;
    logic [ACC_W-1:0] new_acc;

    assign offer    = cfg.cfg_valid && !pend_q;
    assign legal    = (cfg.cfg_int >= CNT_W'(2)) && (cfg.cfg_den != '0) && (cfg.cfg_num < cfg.cfg_den);
    assign accept   = offer && legal;
    assign boundary = (state_q == ST_RUN) && (pcnt_q == plen_q - 1'b1);

    // Configuration feeding the next period: an idle start may use a same-cycle offer,
    // a boundary with a pending shadow restarts the accumulator from zero.
    always_comb begin
        sel_int = act_int_q;
        sel_num = act_num_q;
        sel_den = act_den_q;
        sel_acc = acc_q;
        if (state_q == ST_IDLE) begin
            sel_acc = '0;
            if (accept) begin
                sel_int = cfg.cfg_int;
                sel_num = cfg.cfg_num;
                sel_den = cfg.cfg_den;
            end
        end else if (pend_q) begin
            sel_int = sh_int_q;
            sel_num = sh_num_q;
            sel_den = sh_den_q;
            sel_acc = '0;
        end
    end

    always_comb begin
        sum  = {1'b0, sel_acc} + {1'b0, sel_num};
        diff = sum - {1'b0, sel_den};
        if (sum >= {1'b0, sel_den}) begin
            new_plen = {1'b0, sel_int} + 1'b1;
            new_acc  = diff[ACC_W-1:0];
        end else begin
            new_plen = {1'b0, sel_int};
            new_acc  = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        plen_d    = plen_q;
        acc_d     = acc_q;
        act_int_d = act_int_q;
        act_num_d = act_num_q;
        act_den_d = act_den_q;
        sh_int_d  = sh_int_q;
        sh_num_d  = sh_num_q;
        sh_den_d  = sh_den_q;
        pend_d    = pend_q;
        err_d     = offer && !legal;
        clk_d     = clk_q;

        if (state_q == ST_IDLE || !en) begin
            if (pend_q) begin
                act_int_d = sh_int_q;
                act_num_d = sh_num_q;
                act_den_d = sh_den_q;
                pend_d    = 1'b0;
            end
            if (accept) begin
                act_int_d = cfg.cfg_int;
                act_num_d = cfg.cfg_num;
                act_den_d = cfg.cfg_den;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    pcnt_d  = '0;
                    plen_d  = new_plen;
                    acc_d   = new_acc;
                    clk_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                    acc_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    if (accept) begin
                        sh_int_d = cfg.cfg_int;
                        sh_num_d = cfg.cfg_num;
                        sh_den_d = cfg.cfg_den;
                        pend_d   = 1'b1;
                    end
                    if (boundary) begin
                        if (pend_q) begin
                            act_int_d = sh_int_q;
                            act_num_d = sh_num_q;
                            act_den_d = sh_den_q;
                            pend_d    = 1'b0;
                        end
                        pcnt_d = '0;
                        plen_d = new_plen;
                        acc_d  = new_acc;
                        clk_d  = 1'b1;
                    end else begin
                        // High phase is floor(P/2); the odd extra cycle lands in the low phase.
                        pcnt_d = pcnt_q + 1'b1;
                        clk_d  = (pcnt_q + 1'b1) < (plen_q >> 1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            plen_q    <= {1'b0, CNT_W'(DEF_INT)};
            acc_q     <= '0;
            act_int_q <= CNT_W'(DEF_INT);
            act_num_q <= ACC_W'(DEF_NUM);
            act_den_q <= ACC_W'(DEF_DEN);
            sh_int_q  <= '0;
            sh_num_q  <= '0;
            sh_den_q  <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            plen_q    <= plen_d;
            acc_q     <= acc_d;
            act_int_q <= act_int_d;
            act_num_q <= act_num_d;
            act_den_q <= act_den_d;
            sh_int_q  <= sh_int_d;
            sh_num_q  <= sh_num_d;
            sh_den_q  <= sh_den_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            clk_q     <= clk_d;
        end
    end

    assign period_tick   = boundary;
    assign clk_out       = clk_q;
    assign cfg.cfg_ready = !pend_q;
    assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_frac_clk_div.sv
// tb/tb_frac_clk_div.sv - scoreboard bench for frac_clk_div period lengths and config handshake
module tb_frac_clk_div;
    typedef struct {
        int len;
        int hi;
    } per_t;

    logic clk_in = 1'b0;
    logic rst;
    logic en;
    logic period_tick;
    logic clk_out;

    frac_clk_div_if #(.CNT_W(8), .ACC_W(8)) cif ();

    frac_clk_div #(
        .CNT_W(8), .ACC_W(8), .DEF_INT(8), .DEF_NUM(7), .DEF_DEN(10)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .cfg         (cif.slave),
        .period_tick (period_tick),
        .clk_out     (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int    total = 0;
    int    bad = 0;
    int    tick_cnt = 0;
    int    m_len = 0;
    int    m_hi = 0;
    logic  prev_clk = 1'b0;
    string cur = "none";
    per_t  exp_q[$];

    // Each period begins on a clk_out rise and ends on period_tick; expected shapes are popped per tick.
    always @(negedge clk_in) begin
        per_t e;
        if (clk_out === 1'b1 && prev_clk !== 1'b1) begin
            m_len = 0;
            m_hi  = 0;
        end
        m_len++;
        if (clk_out === 1'b1) m_hi++;
        if (period_tick === 1'b1) begin
            tick_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (m_len !== e.len || m_hi !== e.hi) begin
                    bad++;
                    $display("FAIL %s period: got len=%0d hi=%0d, required len=%0d hi=%0d",
                             cur, m_len, m_hi, e.len, e.hi);
                end
            end
        end
        prev_clk = clk_out;
    end

    task automatic push_per(input int len, input int hi);
        per_t p;
        p.len = len;
        p.hi  = hi;
        exp_q.push_back(p);
    endtask

    task automatic push_default(input int n);
        int seq [10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
        for (int i = 0; i < n; i++) push_per(seq[i % 10], 4);
    endtask

    task automatic offer(input int d, input int num, input int den);
        cif.cfg_valid = 1'b1;
        cif.cfg_int   = 8'(d);
        cif.cfg_num   = 8'(num);
        cif.cfg_den   = 8'(den);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        cif.cfg_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_sb(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        en  = 1'b1;
        offer(1, 0, 1);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset clk_out: got %b required 0", clk_out); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset period_tick: got %b required 0", period_tick); end
        total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset cfg_ready: got %b required 1", cif.cfg_ready); end
        total++; if (cif.cfg_err !== 1'b0) begin bad++; $display("FAIL reset cfg_err: got %b required 0", cif.cfg_err); end
        cif.cfg_valid = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_default();
        bit ok;
        int t0;
        cur = "default";
        do_reset();
        push_default(10);
        t0 = tick_cnt;
        en = 1'b1;
        wait_sb(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL default timeout: got %0d pending, required 0", exp_q.size()); end
        total++; if (tick_cnt - t0 !== 10) begin bad++; $display("FAIL default ticks: got %0d required 10", tick_cnt - t0); end
    endtask

    task automatic test_reconfig();
        bit ok;
        cur = "reconfig";
        do_reset();
        push_per(8, 4);
        for (int i = 0; i < 4; i++) push_per(5, 2);
        en = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        offer(5, 0, 1);
        @(posedge clk_in); #1;
        cif.cfg_valid = 1'b0;
        @(negedge clk_in);
        total++; if (cif.cfg_ready !== 1'b0) begin bad++; $display("FAIL reconfig ready_low: got %b required 0", cif.cfg_ready); end
        @(posedge clk_in); #1;
        offer(1, 0, 1);
        @(posedge clk_in); #1;
        cif.cfg_valid = 1'b0;
        @(negedge clk_in);
        total++; if (cif.cfg_err !== 1'b0) begin bad++; $display("FAIL reconfig ignored_offer err: got %b required 0", cif.cfg_err); end
        wait_sb(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL reconfig timeout: got %0d pending, required 0", exp_q.size()); end
        total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL reconfig ready_back: got %b required 1", cif.cfg_ready); end
    endtask

    task automatic test_illegal();
        bit ok;
        int bad_d  [3] = '{1, 8, 8};
        int bad_n  [3] = '{0, 4, 0};
        int bad_dn [3] = '{1, 4, 0};
        cur = "illegal";
        do_reset();
        push_default(6);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (3) begin @(posedge clk_in); #1; end
            offer(bad_d[i], bad_n[i], bad_dn[i]);
            @(posedge clk_in); #1;
            cif.cfg_valid = 1'b0;
            @(negedge clk_in);
            total++; if (cif.cfg_err !== 1'b1) begin bad++; $display("FAIL illegal%0d cfg_err: got %b required 1", i, cif.cfg_err); end
            total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL illegal%0d cfg_ready: got %b required 1", i, cif.cfg_ready); end
            @(negedge clk_in);
            total++; if (cif.cfg_err !== 1'b0) begin bad++; $display("FAIL illegal%0d err_width: got %b required 0", i, cif.cfg_err); end
        end
        wait_sb(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL illegal timeout: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_d2();
        bit ok;
        cur = "d2";
        do_reset();
        offer(2, 1, 2);
        @(posedge clk_in); #1;
        cif.cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_per(2, 1);
            push_per(3, 1);
        end
        @(negedge clk_in);
        total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL d2 idle_ready: got %b required 1", cif.cfg_ready); end
        @(posedge clk_in); #1;
        en = 1'b1;
        wait_sb(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL d2 timeout: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_en_drop();
        bit ok;
        int t0;
        cur = "en_drop";
        do_reset();
        en = 1'b1;
        repeat (2) begin @(posedge clk_in); #1; end
        en = 1'b0;
        t0 = tick_cnt;
        @(posedge clk_in);
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL en_drop clk_out: got %b required 0", clk_out); end
        repeat (10) @(posedge clk_in);
        #1;
        total++; if (tick_cnt !== t0) begin bad++; $display("FAIL en_drop ticks: got %0d required %0d", tick_cnt, t0); end
        push_default(3);
        en = 1'b1;
        wait_sb(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL en_drop timeout: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_rst_pending();
        bit ok;
        cur = "rst_pending";
        do_reset();
        en = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        offer(5, 0, 1);
        @(posedge clk_in); #1;
        cif.cfg_valid = 1'b0;
        @(negedge clk_in);
        total++; if (cif.cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_pending ready_low: got %b required 0", cif.cfg_ready); end
        @(posedge clk_in); #1;
        rst = 1'b1;
        offer(1, 0, 1);
        @(posedge clk_in); #1;
        cif.cfg_valid = 1'b0;
        @(negedge clk_in);
        total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_pending ready: got %b required 1", cif.cfg_ready); end
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rst_pending clk_out: got %b required 0", clk_out); end
        total++; if (cif.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_pending cfg_err: got %b required 0", cif.cfg_err); end
        @(posedge clk_in); #1;
        exp_q.delete();
        push_default(4);
        rst = 1'b0;
        wait_sb(150, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_pending timeout: got %0d pending, required 0", exp_q.size()); end
        total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_pending ready_after: got %b required 1", cif.cfg_ready); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_int   = '0;
        cif.cfg_num   = '0;
        cif.cfg_den   = '0;
        test_reset();
        test_default();
        test_reconfig();
        test_illegal();
        test_d2();
        test_en_drop();
        test_rst_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
